// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse_gen block: FSM encoding, default counter
// width and the width clamp helper.
package pulse_gen_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    DELAY  = ST_DELAY,
    ACTIVE = ST_ACTIVE,
    GAP    = ST_GAP
  } state_e;

  // A programmed width of zero still produces a one-cycle pulse.
  function automatic logic [31:0] clamp_width(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/pulse_gen_cnt.sv
// Loadable down-counter shared by the delay, active and gap phases of pulse_gen.
module pulse_gen_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pulse_gen.sv
// Programmable delayed pulse generator with enforced low gap and status strobes.
// Define PULSE_GEN_RETRIG_EN to let a trigger during the high phase extend the pulse.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int GAP_MIN = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             trig_pulse,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  output logic             ctrl_level,
  output logic             busy,
  output logic             done_pulse,
  output logic             trig_drop
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LD = (GAP_MIN > 0) ? CNT_W'(GAP_MIN - 1) : '0;
`ifdef PULSE_GEN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  state_e           state, next_state;
  logic [CNT_W-1:0] width_q, cfg_w_clamp, cnt_ld_val;
  logic             cnt_load, cnt_zero, width_ld, drop;

  assign cfg_w_clamp = CNT_W'(clamp_width(32'(cfg_width)));

  pulse_gen_cnt #(.CNT_W(CNT_W)) u_cnt (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .load      (cnt_load),
    .en        (state != IDLE),
    .load_val  (cnt_ld_val),
    .zero      (cnt_zero)
  );

  // Counter is loaded with (phase length - 1) on every phase entry.
  always_comb begin
    next_state = state;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    width_ld   = 1'b0;
    drop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (trig_pulse) begin
          width_ld = 1'b1;
          cnt_load = 1'b1;
          if (cfg_delay == '0) begin
            next_state = ACTIVE;
            cnt_ld_val = cfg_w_clamp - ONE;
          end else begin
            next_state = DELAY;
            cnt_ld_val = cfg_delay - ONE;
          end
        end
      end
      DELAY: begin
        drop = trig_pulse;
        if (cnt_zero) begin
          next_state = ACTIVE;
          cnt_load   = 1'b1;
          cnt_ld_val = width_q - ONE;
        end
      end
      ACTIVE: begin
        if (trig_pulse && RETRIG) begin
          cnt_load   = 1'b1;
          cnt_ld_val = cfg_w_clamp - ONE;
        end else begin
          drop = trig_pulse;
          if (cnt_zero) begin
            next_state = (GAP_MIN > 0) ? GAP : IDLE;
            cnt_load   = 1'b1;
            cnt_ld_val = GAP_LD;
          end
        end
      end
      GAP: begin
        drop = trig_pulse;
        if (cnt_zero) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (width_ld) width_q <= cfg_w_clamp;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      ctrl_level <= 1'b0;
      busy       <= 1'b0;
      done_pulse <= 1'b0;
      trig_drop  <= 1'b0;
    end else begin
      state      <= next_state;
      ctrl_level <= (next_state == ACTIVE);
      busy       <= (next_state != IDLE);
      done_pulse <= (state == ACTIVE) && (next_state != ACTIVE);
      trig_drop  <= drop;
    end
  end

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: two instances (GAP_MIN=1 and GAP_MIN=0) checked every
// cycle against an interval-based reference model.
module tb_pulse_gen;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       trig_pulse = 1'b0;
  logic [7:0] cfg_delay = '0;
  logic [7:0] cfg_width = '0;
  logic [1:0] lvl, bsy, dn, drp;

`ifdef PULSE_GEN_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  always #5 sys_clk = ~sys_clk;

  pulse_gen #(.CNT_W(8), .GAP_MIN(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .trig_pulse(trig_pulse),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .ctrl_level(lvl[0]), .busy(bsy[0]), .done_pulse(dn[0]), .trig_drop(drp[0])
  );

  pulse_gen #(.CNT_W(8), .GAP_MIN(0)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .trig_pulse(trig_pulse),
    .cfg_delay(cfg_delay), .cfg_width(cfg_width),
    .ctrl_level(lvl[1]), .busy(bsy[1]), .done_pulse(dn[1]), .trig_drop(drp[1])
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gap_min[2] = '{1, 0};
  // Model: pulse high interval [rise,fall], busy interval (acc,bend], drop strobe cycle.
  int rise[2], fall[2], bend[2], acc[2], dropc[2];

  task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s[gap=%0d] cyc=%0d observed=%b expected=%b", tag, gap_min[idx], cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rise[i] = -9; fall[i] = -10; bend[i] = -10; acc[i] = -10; dropc[i] = -10;
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      chk("ctrl_level", i, lvl[i], (cyc >= rise[i]) && (cyc <= fall[i]));
      chk("busy",       i, bsy[i], (cyc > acc[i]) && (cyc <= bend[i]));
      chk("done_pulse", i, dn[i],  cyc == fall[i] + 1);
      chk("trig_drop",  i, drp[i], cyc == dropc[i]);
    end
  endtask

  task automatic model_trig(input int i, input int d, input int w);
    int wc;
    wc = (w == 0) ? 1 : w;
    if (cyc > bend[i]) begin
      acc[i]  = cyc;
      rise[i] = cyc + 1 + d;
      fall[i] = cyc + d + wc;
      bend[i] = fall[i] + gap_min[i];
    end else if (RETRIG && cyc >= rise[i] && cyc <= fall[i]) begin
      fall[i] = cyc + wc;
      bend[i] = fall[i] + gap_min[i];
    end else begin
      dropc[i] = cyc + 1;
    end
  endtask

  task automatic step(input bit tr, input int d, input int w);
    check_cycle();
    trig_pulse = tr;
    cfg_delay  = d[7:0];
    cfg_width  = w[7:0];
    if (tr) for (int i = 0; i < 2; i++) model_trig(i, d, w);
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 0, 0);
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_level"}, i, lvl[i], 1'b0);
      chk({tag, "_busy"},  i, bsy[i], 1'b0);
      chk({tag, "_done"},  i, dn[i],  1'b0);
      chk({tag, "_drop"},  i, drp[i], 1'b0);
    end
  endtask

  task automatic do_reset();
    sys_rst_n  = 1'b0;
    trig_pulse = 1'b0;
    #1;
    chk_zero("rst_mid");
    model_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    chk_zero("rst");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // D=0, W=3
    idle(10); step(1'b1, 0, 3); idle(8);
    // D=5, W=0 (clamped)
    step(1'b1, 5, 0); idle(12);
    // busy trigger dropped, later one accepted
    step(1'b1, 0, 4); idle(2); step(1'b1, 0, 4); idle(3); step(1'b1, 0, 4); idle(10);
    // trigger during high phase (retrigger or drop depending on build)
    step(1'b1, 0, 4); idle(1); step(1'b1, 0, 3); idle(10);
    // held trigger
    step(1'b1, 2, 2); step(1'b1, 2, 2); step(1'b1, 2, 2); idle(10);
    // W=1 back-to-back
    step(1'b1, 0, 1); idle(1); step(1'b1, 0, 1); idle(6);
    // reset in the middle of a pulse, then a fresh trigger
    step(1'b1, 0, 6); idle(2); do_reset(); step(1'b1, 1, 2); idle(8);

    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 6)), int'($urandom_range(0, 5)));
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
